// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NREQ byte producers.
// Optional burst lock is compiled in with UART_ARB_LOCK_EN.
module uart_tx_arbiter #(
  parameter int NREQ    = 4,
  parameter int IDW     = 2,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req,
  input  logic [8*NREQ-1:0] req_data,
  input  logic [NREQ-1:0]   req_lock,
  output logic [NREQ-1:0]   ack,
  output logic [7:0]        tx_data,
  output logic              tx_start,
  input  logic              tx_busy,
  output logic [IDW-1:0]    grant_id,
  output logic              busy,
  output logic              timeout_err,
  output logic [7:0]        err_cnt
);

  localparam int CW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, WAIT_BUSY, WAIT_DONE} state_t;

  state_t         state;
  logic [IDW-1:0] ptr;
  logic [CW-1:0]  cnt;
  logic [IDW-1:0] win;
  logic [IDW-1:0] next_ptr;
  logic           keep_ptr;

  // Scan from the far end down so the closest requester to ptr is written last.
  always_comb begin
    win = '0;
    for (int k = NREQ-1; k >= 0; k--) begin
      if (req[(int'(ptr) + k) % NREQ]) win = IDW'((int'(ptr) + k) % NREQ);
    end
  end

  assign next_ptr = (grant_id == IDW'(NREQ-1)) ? '0 : grant_id + 1'b1;

`ifdef UART_ARB_LOCK_EN
  logic lock_hold;

  // Captured at the ack edge; every new grant recaptures it, and the
  // timeout path advances ptr unconditionally, so no explicit clear is needed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     lock_hold <= 1'b0;
    else if (state == IDLE && |req) lock_hold <= req_lock[win];
  end

  assign keep_ptr = lock_hold;
`else
  logic unused_lock;
  assign unused_lock = ^req_lock;
  assign keep_ptr    = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      ptr         <= '0;
      cnt         <= '0;
      grant_id    <= '0;
      ack         <= '0;
      tx_data     <= 8'h00;
      tx_start    <= 1'b0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
      err_cnt     <= 8'h00;
    end else begin
      ack         <= '0;
      tx_start    <= 1'b0;
      timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          if (|req) begin
            grant_id <= win;
            tx_data  <= req_data[8*win +: 8];
            tx_start <= 1'b1;
            ack      <= NREQ'(1) << win;
            cnt      <= '0;
            busy     <= 1'b1;
            state    <= WAIT_BUSY;
          end
        end
        WAIT_BUSY: begin
          if (tx_busy) begin
            state <= WAIT_DONE;
          end else if (cnt == CW'(TIMEOUT-1)) begin
            timeout_err <= 1'b1;
            if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
            ptr   <= next_ptr;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WAIT_DONE: begin
          if (!tx_busy) begin
            ptr   <= keep_ptr ? grant_id : next_ptr;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed + randomized bench for uart_tx_arbiter against a queue-free priority model.
module tb_uart_tx_arbiter;
  localparam int NREQ    = 4;
  localparam int IDW     = 2;
  localparam int TIMEOUT = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req;
  logic [8*NREQ-1:0] req_data;
  logic [NREQ-1:0]   req_lock;
  logic [NREQ-1:0]   ack;
  logic [7:0]        tx_data;
  logic              tx_start;
  logic              tx_busy;
  logic [IDW-1:0]    grant_id;
  logic              busy;
  logic              timeout_err;
  logic [7:0]        err_cnt;

  int checks = 0;
  int errors = 0;
  int m_ptr  = 0;   // requester with highest priority next
  int m_err  = 0;   // expected timeout count

  uart_tx_arbiter #(.NREQ(NREQ), .IDW(IDW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data), .req_lock(req_lock),
    .ack(ack), .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
    .grant_id(grant_id), .busy(busy), .timeout_err(timeout_err), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_ack"}, 32'(ack), 0);
    check({tag, "_tx_start"}, 32'(tx_start), 0);
    check({tag, "_tx_data"}, 32'(tx_data), 0);
    check({tag, "_grant_id"}, 32'(grant_id), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_timeout_err"}, 32'(timeout_err), 0);
    check({tag, "_err_cnt"}, 32'(err_cnt), 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req = '0; req_lock = '0; req_data = '0; tx_busy = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_vals("rst");
    rst_n = 1'b1;
    @(negedge clk);
    m_ptr = 0;
    m_err = 0;
  endtask

  function automatic int model_win(input logic [NREQ-1:0] r);
    for (int k = 0; k < NREQ; k++)
      if (r[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
    return -1;
  endfunction

  // One byte: request, check grant, then either serve it with a transmitter
  // that goes busy dly cycles after start for len cycles, or let it time out.
  task automatic xfer(input logic [NREQ-1:0] r, input logic [NREQ-1:0] lk,
                      input logic [8*NREQ-1:0] d, input int dly, input int len,
                      input bit to, output int gid);
    int w;
    w = model_win(r);
    req = r; req_lock = lk; req_data = d;
    @(negedge clk);
    gid = int'(grant_id);
    check("tx_start", 32'(tx_start), 1);
    check("ack", 32'(ack), 32'(1) << w);
    check("tx_data", 32'(tx_data), 32'(d[8*w +: 8]));
    check("grant_id", 32'(grant_id), 32'(w));
    check("busy_rise", 32'(busy), 1);
    req = '0; req_lock = '0;
    if (to) begin
      for (int k = 1; k <= TIMEOUT; k++) begin
        @(negedge clk);
        if (k == 1) check("start_width", 32'(tx_start), 0);
        if (k == TIMEOUT-1) check("no_early_to", 32'(timeout_err), 0);
      end
      m_err = (m_err < 255) ? m_err + 1 : 255;
      check("timeout_err", 32'(timeout_err), 1);
      check("err_cnt", 32'(err_cnt), 32'(m_err));
      check("busy_after_to", 32'(busy), 0);
      m_ptr = (w + 1) % NREQ;
    end else begin
      if (dly == 0) tx_busy = 1'b1;
      for (int k = 1; k <= dly + len; k++) begin
        @(negedge clk);
        if (k == 1) check("ack_width", 32'(ack), 0);
        if (k == dly) tx_busy = 1'b1;
      end
      check("busy_hold", 32'(busy), 1);
      tx_busy = 1'b0;
      @(negedge clk);
      check("busy_fall", 32'(busy), 0);
      check("no_early_start", 32'(tx_start), 0);
`ifdef UART_ARB_LOCK_EN
      m_ptr = lk[w] ? w : (w + 1) % NREQ;
`else
      m_ptr = (w + 1) % NREQ;
`endif
    end
  endtask

  initial begin
    int g;
    int starts;
    int exp_lock[4];

    do_reset();

    // single byte
    xfer(4'b0001, 4'b0000, 32'h0000_00A5, 3, 20, 1'b0, g);
    check("single_gid", 32'(g), 0);

    // fairness with all requesters held
    do_reset();
    for (int i = 0; i < 5; i++) begin
      xfer(4'b1111, 4'b0000, 32'h1312_1110, 3, 5, 1'b0, g);
      check("fair_gid", 32'(g), 32'(i % 4));
    end

    // timeout with the transmitter dead
    xfer(4'b0010, 4'b0000, 32'h0000_3C00, 0, 0, 1'b1, g);
    check("to_gid", 32'(g), 1);

    // burst lock
    do_reset();
`ifdef UART_ARB_LOCK_EN
    exp_lock = '{0, 0, 0, 1};
`else
    exp_lock = '{0, 1, 0, 1};
`endif
    for (int i = 0; i < 4; i++) begin
      xfer(4'b0011, (i < 2) ? 4'b0001 : 4'b0000, 32'h0000_BBAA, 2, 4, 1'b0, g);
      check("lock_gid", 32'(g), 32'(exp_lock[i]));
    end

    // reset while in WAIT_DONE
    req = 4'b0100; req_data = 32'h00C3_0000;
    @(negedge clk);
    check("mid_start", 32'(tx_start), 1);
    req = '0; tx_busy = 1'b1;
    repeat (4) @(negedge clk);
    check("mid_busy", 32'(busy), 1);
    rst_n = 1'b0;
    #1;
    check_reset_vals("midrst");
    @(negedge clk);
    check_reset_vals("midrst_hold");
    rst_n = 1'b1;
    starts = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (k == 4) tx_busy = 1'b0;
      if (tx_start) starts++;
    end
    check("no_spurious_start", 32'(starts), 0);
    m_ptr = 0; m_err = 0;

    // randomized traffic
    for (int i = 0; i < 40; i++) begin
      xfer(4'($urandom_range(1, 15)), 4'($urandom_range(0, 15)), $urandom,
           int'($urandom_range(0, 5)), int'($urandom_range(1, 6)),
           ($urandom_range(0, 5) == 0), g);
    end

    // saturation
    do_reset();
    for (int i = 0; i < 300; i++)
      xfer(4'($urandom_range(1, 15)), 4'b0000, $urandom, 0, 0, 1'b1, g);
    check("err_sat", 32'(err_cnt), 255);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
